ped_crossing_ctrl: RTL and testbench

- Downstream consumer of the traffic light controller's one-hot red/yellow/green lamp outputs.
- Latches pedestrian button requests.
- Grants a WALK phase inside the vehicle red phase, then a flashing DON'T WALK clearance phase with a countdown.
- Forces solid DON'T WALK on any lamp anomaly (sticky fault).

---
 rtl/ped_crossing_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller.
// Watches the vehicle lamps (one-hot red/yellow/green), latches pedestrian
// requests, grants WALK at the start of a red phase, follows it with a
// flashing DON'T WALK clearance countdown, and locks into a sticky fault with
// solid DON'T WALK whenever the lamps stop being one-hot.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 12,
  parameter int CLEAR_CYCLES = 16,
  parameter int FLASH_HALF   = 2,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic             flash,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             fault
);

  // Phase counter covers both the WALK length and the flash half-period.
  localparam int PH_W = $clog2(WALK_CYCLES + FLASH_HALF + 1);

  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0]  WALK_LAST  = PH_W'(WALK_CYCLES);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] CD_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    CLEAR = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [PH_W-1:0]   phase_cnt_r, phase_cnt_s;
  logic              red_q_r;
  logic              walk_r, walk_s;
  logic              dont_walk_r, dont_walk_s;
  logic              flash_r, flash_s;
  logic [CNT_W-1:0]  countdown_r, countdown_s;
  logic              req_pending_r, req_pending_s;
  logic              fault_r, fault_s;
  logic              red_rise_s;
  logic              lamps_ok_s;

  assign red_rise_s = red & ~red_q_r;

  // Lamp sanity: exactly one of red/yellow/green must be lit.
  always_comb begin
    lamps_ok_s = 1'b0;
    case ({red, yellow, green})
      3'b100:  lamps_ok_s = 1'b1;
      3'b010:  lamps_ok_s = 1'b1;
      3'b001:  lamps_ok_s = 1'b1;
      default: lamps_ok_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs default to solid DON'T WALK.
  always_comb begin
    state_s       = state_r;
    phase_cnt_s   = phase_cnt_r;
    walk_s        = 1'b0;
    dont_walk_s   = 1'b1;
    flash_s       = 1'b0;
    countdown_s   = '0;
    fault_s       = fault_r;
    req_pending_s = req_pending_r;

    // Requests latch in every state except WALK, where presses are ignored.
    if (ped_req && (state_r != WALK)) begin
      req_pending_s = 1'b1;
    end else begin
      req_pending_s = req_pending_r;
    end

    if (!lamps_ok_s || (state_r == FAULT)) begin
      // Lamp anomaly wins over everything and only reset clears it.
      state_s       = FAULT;
      fault_s       = 1'b1;
      req_pending_s = 1'b0;
      phase_cnt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (red_rise_s && (req_pending_r || ped_req)) begin
            state_s       = WALK;
            phase_cnt_s   = PH_ONE;
            walk_s        = 1'b1;
            dont_walk_s   = 1'b0;
            req_pending_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        WALK: begin
          if (!red) begin
            // Red ended early: abandon the crossing without a fault.
            state_s     = IDLE;
            phase_cnt_s = '0;
          end else if (phase_cnt_r == WALK_LAST) begin
            state_s     = CLEAR;
            phase_cnt_s = PH_ONE;
            flash_s     = 1'b1;
            dont_walk_s = 1'b1;
            countdown_s = CLEAR_LOAD;
          end else begin
            phase_cnt_s = phase_cnt_r + PH_ONE;
            walk_s      = 1'b1;
            dont_walk_s = 1'b0;
          end
        end
        CLEAR: begin
          if (!red) begin
            state_s     = IDLE;
            phase_cnt_s = '0;
          end else if (countdown_r == CD_ONE) begin
            // Red still lit at the end of clearance: hold until it goes out.
            state_s     = HOLD;
            phase_cnt_s = '0;
          end else begin
            flash_s     = 1'b1;
            countdown_s = countdown_r - CD_ONE;
            if (phase_cnt_r == HALF_LAST) begin
              dont_walk_s = ~dont_walk_r;
              phase_cnt_s = PH_ONE;
            end else begin
              dont_walk_s = dont_walk_r;
              phase_cnt_s = phase_cnt_r + PH_ONE;
            end
          end
        end
        HOLD: begin
          if (!red) begin
            state_s = IDLE;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          // Any unexpected encoding is treated as a fault.
          state_s       = FAULT;
          fault_s       = 1'b1;
          req_pending_s = 1'b0;
          phase_cnt_s   = '0;
        end
      endcase
    end
  end

  // State and output registers; red_q starts high so leaving reset mid-red is not a red edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      phase_cnt_r   <= '0;
      red_q_r       <= 1'b1;
      walk_r        <= 1'b0;
      dont_walk_r   <= 1'b1;
      flash_r       <= 1'b0;
      countdown_r   <= '0;
      req_pending_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      phase_cnt_r   <= phase_cnt_s;
      red_q_r       <= red;
      walk_r        <= walk_s;
      dont_walk_r   <= dont_walk_s;
      flash_r       <= flash_s;
      countdown_r   <= countdown_s;
      req_pending_r <= req_pending_s;
      fault_r       <= fault_s;
    end
  end

  assign walk        = walk_r;
  assign dont_walk   = dont_walk_r;
  assign flash       = flash_r;
  assign countdown   = countdown_r;
  assign req_pending = req_pending_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed light sequences plus randomized light
// timing and button presses, checked every cycle against a timeline model.
module tb_ped_crossing_ctrl;

  localparam int W  = 12;
  localparam int C  = 16;
  localparam int FH = 2;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          red, yellow, green, ped_req;
  logic          walk, dont_walk, flash, req_pending, fault;
  logic [CW-1:0] countdown;

  int errors = 0;
  int checks = 0;

  // Reference model: crossing described as "cycles elapsed since grant".
  bit m_fault, m_active, m_pending, m_prev_red;
  int m_t;

  ped_crossing_ctrl #(
    .WALK_CYCLES(W), .CLEAR_CYCLES(C), .FLASH_HALF(FH), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .ped_req(ped_req), .walk(walk), .dont_walk(dont_walk), .flash(flash),
    .countdown(countdown), .req_pending(req_pending), .fault(fault)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fault    = 1'b0;
    m_active   = 1'b0;
    m_pending  = 1'b0;
    m_prev_red = 1'b1;
    m_t        = 0;
  endtask

  task automatic model_step(input bit r, input bit y, input bit g, input bit p);
    bit valid, rise, in_walk, granted;
    valid   = (int'(r) + int'(y) + int'(g)) == 1;
    rise    = r && !m_prev_red;
    in_walk = m_active && (m_t < W);
    granted = 1'b0;
    m_prev_red = r;
    if (!valid) m_fault = 1'b1;
    if (m_fault) begin
      m_active  = 1'b0;
      m_pending = 1'b0;
    end else begin
      if (m_active && !r) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_t++;
        if (m_t >= W + C) m_active = 1'b0;
      end else if (rise && (m_pending || p)) begin
        m_active = 1'b1;
        m_t      = 0;
        granted  = 1'b1;
      end
      if (granted) m_pending = 1'b0;
      else if (p && !in_walk) m_pending = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    bit e_walk, e_dw, e_fl;
    int e_cd, k;
    e_walk = 1'b0; e_dw = 1'b1; e_fl = 1'b0; e_cd = 0;
    if (!m_fault && m_active) begin
      if (m_t < W) begin
        e_walk = 1'b1;
        e_dw   = 1'b0;
      end else begin
        k    = m_t - W;
        e_fl = 1'b1;
        e_cd = C - k;
        e_dw = ((k / FH) % 2) == 0;
      end
    end
    check({tag, ".walk"},        32'(walk),        32'(e_walk));
    check({tag, ".dont_walk"},   32'(dont_walk),   32'(e_dw));
    check({tag, ".flash"},       32'(flash),       32'(e_fl));
    check({tag, ".countdown"},   32'(countdown),   32'(e_cd));
    check({tag, ".req_pending"}, 32'(req_pending), 32'(m_pending));
    check({tag, ".fault"},       32'(fault),       32'(m_fault));
  endtask

  // n cycles with fixed lamps; ped_req pressed with probability pct percent.
  task automatic run(input string tag, input bit r, input bit y, input bit g,
                     input int n, input int pct);
    bit p;
    for (int i = 0; i < n; i++) begin
      p = ($urandom_range(0, 99) < pct);
      red = r; yellow = y; green = g; ped_req = p;
      @(posedge clk);
      #1;
      model_step(r, y, g, p);
      check_outputs(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    red = 1'b1; yellow = 1'b0; green = 1'b0; ped_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".walk"},        32'(walk),        32'd0);
    check({tag, ".dont_walk"},   32'(dont_walk),   32'd1);
    check({tag, ".flash"},       32'(flash),       32'd0);
    check({tag, ".countdown"},   32'(countdown),   32'd0);
    check({tag, ".req_pending"}, 32'(req_pending), 32'd0);
    check({tag, ".fault"},       32'(fault),       32'd0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; red = 1'b1; yellow = 1'b0; green = 1'b0; ped_req = 1'b1;
    model_reset();

    // 1: reset held mid-red with a press; no walk until the next red edge.
    do_reset("t1_reset");
    run("t1_red_press", 1'b1, 1'b0, 1'b0, 5, 100);
    run("t1_red",       1'b1, 1'b0, 1'b0, 10, 0);
    run("t1_green",     1'b0, 1'b0, 1'b1, 20, 0);
    run("t1_yellow",    1'b0, 1'b1, 1'b0, 4, 0);
    run("t1_red2",      1'b1, 1'b0, 1'b0, 32, 0);
    run("t1_green2",    1'b0, 1'b0, 1'b1, 10, 0);

    // 2: single press in green, full walk / clear / hold cycle.
    run("t2_green",  1'b0, 1'b0, 1'b1, 3, 0);
    run("t2_press",  1'b0, 1'b0, 1'b1, 1, 100);
    run("t2_green",  1'b0, 1'b0, 1'b1, 10, 0);
    run("t2_yellow", 1'b0, 1'b1, 1'b0, 4, 0);
    run("t2_red",    1'b1, 1'b0, 1'b0, 32, 0);
    run("t2_green2", 1'b0, 1'b0, 1'b1, 5, 0);

    // 3: two full light cycles without a press.
    for (int i = 0; i < 2; i++) begin
      run("t3_green",  1'b0, 1'b0, 1'b1, 20, 0);
      run("t3_yellow", 1'b0, 1'b1, 1'b0, 4, 0);
      run("t3_red",    1'b1, 1'b0, 1'b0, 32, 0);
    end

    // 4: press only on the red edge cycle, then presses during WALK.
    run("t4_green",     1'b0, 1'b0, 1'b1, 5, 0);
    run("t4_yellow",    1'b0, 1'b1, 1'b0, 4, 0);
    run("t4_rise",      1'b1, 1'b0, 1'b0, 1, 100);
    run("t4_walk",      1'b1, 1'b0, 1'b0, 2, 0);
    run("t4_walkpress", 1'b1, 1'b0, 1'b0, 3, 100);
    run("t4_red",       1'b1, 1'b0, 1'b0, 26, 0);
    run("t4_green2",    1'b0, 1'b0, 1'b1, 10, 0);

    // 5: early red end in WALK, then an anomaly and sticky fault.
    run("t5_press",   1'b0, 1'b0, 1'b1, 1, 100);
    run("t5_green",   1'b0, 1'b0, 1'b1, 5, 0);
    run("t5_yellow",  1'b0, 1'b1, 1'b0, 4, 0);
    run("t5_walk",    1'b1, 1'b0, 1'b0, 5, 0);
    run("t5_early",   1'b0, 1'b0, 1'b1, 1, 0);
    run("t5_green2",  1'b0, 1'b0, 1'b1, 4, 0);
    run("t5_anomaly", 1'b1, 1'b0, 1'b1, 1, 0);
    run("t5_stuck_g", 1'b0, 1'b0, 1'b1, 5, 0);
    run("t5_stuck_y", 1'b0, 1'b1, 1'b0, 3, 0);
    run("t5_stuck_r", 1'b1, 1'b0, 1'b0, 10, 50);
    do_reset("t5_reset");

    // 6: press during CLEAR pends through HOLD and the next green.
    run("t6_red",    1'b1, 1'b0, 1'b0, 3, 0);
    run("t6_green",  1'b0, 1'b0, 1'b1, 4, 0);
    run("t6_press",  1'b0, 1'b0, 1'b1, 1, 100);
    run("t6_green",  1'b0, 1'b0, 1'b1, 5, 0);
    run("t6_yellow", 1'b0, 1'b1, 1'b0, 4, 0);
    run("t6_red",    1'b1, 1'b0, 1'b0, 20, 0);
    run("t6_clrprs", 1'b1, 1'b0, 1'b0, 1, 100);
    run("t6_red",    1'b1, 1'b0, 1'b0, 11, 0);
    run("t6_green2", 1'b0, 1'b0, 1'b1, 20, 0);
    run("t6_yellow2",1'b0, 1'b1, 1'b0, 4, 0);
    run("t6_red2",   1'b1, 1'b0, 1'b0, 32, 0);
    run("t6_green3", 1'b0, 1'b0, 1'b1, 5, 0);

    // Randomized light timing (including short reds) and random presses.
    for (int i = 0; i < 10; i++) begin
      run("rnd_green",  1'b0, 1'b0, 1'b1, int'($urandom_range(6, 30)), 8);
      run("rnd_yellow", 1'b0, 1'b1, 1'b0, int'($urandom_range(2, 6)), 8);
      run("rnd_red",    1'b1, 1'b0, 1'b0, int'($urandom_range(10, 40)), 8);
    end
    run("rnd_anomaly", 1'b0, 1'b0, 1'b0, 1, 0);
    run("rnd_after",   1'b0, 1'b0, 1'b1, 6, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
